// File: rtl/nvdla_csb_req_initiator_if.sv
// rtl/nvdla_csb_req_initiator_if.sv - host command, CSB request/response and host completion bundle
interface nvdla_csb_req_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [21:0] cmd_addr;
    logic [31:0] cmd_wdat;
    logic        cmd_write;
    logic        cmd_nposted;
    logic [3:0]  cmd_wrbe;
    logic        csb_req_pvld;
    logic        csb_req_prdy;
    logic [62:0] csb_req_pd;
    logic        csb_resp_valid;
    logic [33:0] csb_resp_pd;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic        host_rsp_error;
    logic        host_rsp_timeout;
    logic        unexpected_resp;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted, cmd_wrbe,
        input  csb_req_prdy, csb_resp_valid, csb_resp_pd,
        output cmd_ready, csb_req_pvld, csb_req_pd,
        output host_rsp_valid, host_rsp_rdata, host_rsp_error, host_rsp_timeout,
        output unexpected_resp, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted, cmd_wrbe,
        output csb_req_prdy, csb_resp_valid, csb_resp_pd,
        input  cmd_ready, csb_req_pvld, csb_req_pd,
        input  host_rsp_valid, host_rsp_rdata, host_rsp_error, host_rsp_timeout,
        input  unexpected_resp, busy
    );
endinterface

// File: rtl/nvdla_csb_req_initiator.sv
// rtl/nvdla_csb_req_initiator.sv - single-outstanding CSB master with response timeout
module nvdla_csb_req_initiator #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int CNT_W          = 16
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    nvdla_csb_req_initiator_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [62:0]      req_pd;
    logic [62:0]      cmd_pd;
    logic             load_cmd;
    logic             rsp_fire;
    logic             rsp_err;
    logic             rsp_to;
    logic [31:0]      rsp_rdata;
    logic             unexp_nxt;
    logic             pend_write;
    logic             pend_posted;
    logic             resp_match;

    // Reads carry no write data and never request an acknowledge.
    assign cmd_pd = {2'b00, bus.cmd_wrbe, 1'b0,
                     bus.cmd_write & bus.cmd_nposted, bus.cmd_write,
                     bus.cmd_write ? bus.cmd_wdat : 32'd0, bus.cmd_addr};

    assign pend_write  = req_pd[54];
    assign pend_posted = req_pd[54] & ~req_pd[55];
    assign resp_match  = bus.csb_resp_pd[33] == pend_write;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_cmd  = 1'b0;
        rsp_fire  = 1'b0;
        rsp_err   = 1'b0;
        rsp_to    = 1'b0;
        rsp_rdata = 32'd0;
        unexp_nxt = 1'b0;
        case (state)
            IDLE: begin
                unexp_nxt = bus.csb_resp_valid;
                if (bus.cmd_valid) begin
                    load_cmd  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                unexp_nxt = bus.csb_resp_valid;
                if (bus.csb_req_prdy) begin
                    cnt_nxt = '0;
                    if (pend_posted) begin
                        rsp_fire  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // A matching response beats a timeout landing in the same cycle.
                if (bus.csb_resp_valid && resp_match) begin
                    rsp_fire  = 1'b1;
                    rsp_err   = bus.csb_resp_pd[32];
                    rsp_rdata = pend_write ? 32'd0 : bus.csb_resp_pd[31:0];
                    state_nxt = IDLE;
                end else begin
                    unexp_nxt = bus.csb_resp_valid;
                    if (cnt == CNT_LAST) begin
                        rsp_fire  = 1'b1;
                        rsp_err   = 1'b1;
                        rsp_to    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt                  <= '0;
            req_pd               <= '0;
            bus.host_rsp_valid   <= 1'b0;
            bus.host_rsp_rdata   <= 32'd0;
            bus.host_rsp_error   <= 1'b0;
            bus.host_rsp_timeout <= 1'b0;
            bus.unexpected_resp  <= 1'b0;
        end else begin
            cnt                 <= cnt_nxt;
            bus.host_rsp_valid  <= rsp_fire;
            bus.unexpected_resp <= unexp_nxt;
            if (load_cmd) begin
                req_pd <= cmd_pd;
            end
            // Completion data holds until the next completion.
            if (rsp_fire) begin
                bus.host_rsp_rdata   <= rsp_rdata;
                bus.host_rsp_error   <= rsp_err;
                bus.host_rsp_timeout <= rsp_to;
            end
        end
    end

    assign bus.cmd_ready    = (state == IDLE);
    assign bus.csb_req_pvld = (state == REQ);
    assign bus.csb_req_pd   = req_pd;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_nvdla_csb_req_initiator.sv
// tb/tb_nvdla_csb_req_initiator.sv - randomized self-checking bench with a transaction-level model
module tb_nvdla_csb_req_initiator;
    localparam int T   = 8;
    localparam int LEN = T + 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nvdla_csb_req_initiator_if bus();

    nvdla_csb_req_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rsp_cnt = 0;
    int          unexp_cnt = 0;
    int          rsp_cyc = -1;
    logic [31:0] rsp_rdata_seen = '0;
    logic        rsp_err_seen = 1'b0;
    logic        rsp_to_seen = 1'b0;
    always @(negedge clk) begin
        if (bus.host_rsp_valid === 1'b1) begin
            rsp_cnt        <= rsp_cnt + 1;
            rsp_cyc        <= cyc;
            rsp_rdata_seen <= bus.host_rsp_rdata;
            rsp_err_seen   <= bus.host_rsp_error;
            rsp_to_seen    <= bus.host_rsp_timeout;
        end
        if (bus.unexpected_resp === 1'b1) unexp_cnt <= unexp_cnt + 1;
    end

    // Slave response script, offsets counted from the first cycle after the handshake.
    int          n_resp;
    int          resp_off [3];
    logic [33:0] resp_pd  [3];

    logic [62:0] pd_first;
    bit          pd_stable, pvld_after, acc_ready, rdy_at_rsp;
    int          hs_cyc, rsp0, unexp0;

    int          exp_rel, exp_unexp;
    logic        exp_err, exp_to;
    logic [31:0] exp_rdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [62:0] exp_pd(input logic [21:0] a, input logic [31:0] d,
                                           input logic w, input logic np, input logic [3:0] be);
        logic [62:0] p;
        p        = '0;
        p[21:0]  = a;
        p[53:22] = w ? d : 32'd0;
        p[54]    = w;
        p[55]    = w & np;
        p[60:57] = be;
        return p;
    endfunction

    task automatic model_txn(input logic w, input logic np);
        int done;
        done      = -1;
        exp_unexp = 0;
        exp_err   = 1'b0;
        exp_to    = 1'b0;
        exp_rdata = 32'd0;
        if (w && !np) begin
            exp_rel   = 1;
            exp_unexp = n_resp;
        end else begin
            for (int k = 0; k < LEN; k++) begin
                for (int j = 0; j < n_resp; j++) begin
                    if (resp_off[j] == k) begin
                        if (done < 0 && k < T && resp_pd[j][33] == w) begin
                            done      = k;
                            exp_err   = resp_pd[j][32];
                            exp_rdata = w ? 32'd0 : resp_pd[j][31:0];
                        end else begin
                            exp_unexp++;
                        end
                    end
                end
            end
            if (done < 0) begin
                exp_rel = T + 1;
                exp_err = 1'b1;
                exp_to  = 1'b1;
            end else begin
                exp_rel = done + 2;
            end
        end
    endtask

    task automatic run_txn(input logic [21:0] a, input logic [31:0] d, input logic w,
                           input logic np, input logic [3:0] be, input int pdly);
        rsp0 = rsp_cnt;
        unexp0 = unexp_cnt;
        rdy_at_rsp = 1'b0;
        bus.cmd_addr = a; bus.cmd_wdat = d; bus.cmd_write = w;
        bus.cmd_nposted = np; bus.cmd_wrbe = be; bus.cmd_valid = 1'b1;
        acc_ready = bus.cmd_ready;
        tick;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = 22'($urandom);
        bus.cmd_wdat = $urandom;
        pd_first = bus.csb_req_pd;
        pd_stable = 1'b1;
        bus.csb_req_prdy = 1'b0;
        for (int i = 0; i < pdly; i++) begin
            if (bus.csb_req_pd !== pd_first || bus.csb_req_pvld !== 1'b1) pd_stable = 1'b0;
            tick;
        end
        bus.csb_req_prdy = 1'b1;
        if (bus.csb_req_pd !== pd_first || bus.csb_req_pvld !== 1'b1) pd_stable = 1'b0;
        hs_cyc = cyc;
        tick;
        bus.csb_req_prdy = 1'b0;
        pvld_after = bus.csb_req_pvld;
        for (int k = 0; k < LEN; k++) begin
            if (bus.host_rsp_valid === 1'b1) rdy_at_rsp = bus.cmd_ready;
            bus.csb_resp_valid = 1'b0;
            for (int j = 0; j < n_resp; j++) begin
                if (resp_off[j] == k) begin
                    bus.csb_resp_valid = 1'b1;
                    bus.csb_resp_pd = resp_pd[j];
                end
            end
            tick;
        end
        bus.csb_resp_valid = 1'b0;
        bus.csb_resp_pd = {2'($urandom), $urandom};
        tick;
    endtask

    task automatic test_reset;
        bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_wdat = 0; bus.cmd_write = 0;
        bus.cmd_nposted = 0; bus.cmd_wrbe = 0; bus.csb_req_prdy = 0;
        bus.csb_resp_valid = 0; bus.csb_resp_pd = 0;
        #1;
        total++; if (bus.csb_req_pvld !== 1'b0) begin bad++; $display("FAIL reset_pvld got=%b exp=0", bus.csb_req_pvld); end
        total++; if (bus.csb_req_pd !== 63'd0) begin bad++; $display("FAIL reset_pd got=%h exp=0", bus.csb_req_pd); end
        total++; if ({bus.host_rsp_valid, bus.host_rsp_error, bus.host_rsp_timeout, bus.unexpected_resp} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.host_rsp_valid, bus.host_rsp_error, bus.host_rsp_timeout, bus.unexpected_resp}); end
        total++; if (bus.host_rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.host_rsp_rdata); end
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle ready=%b busy=%b exp 1/0", bus.cmd_ready, bus.busy); end
        repeat (3) tick;
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_read_basic;
        n_resp = 1; resp_off[0] = 1; resp_pd[0] = {1'b0, 1'b0, 32'hDEADBEEF};
        model_txn(1'b0, 1'b0);
        run_txn(22'h000001, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 0);
        total++; if (pd_first[21:0] !== 22'h000001 || pd_first[54] !== 1'b0) begin bad++; $display("FAIL read_pd got=%h", pd_first); end
        total++; if (pd_first !== exp_pd(22'h000001, 32'h1234_5678, 1'b0, 1'b1, 4'hF)) begin bad++; $display("FAIL read_pd_full got=%h exp=%h", pd_first, exp_pd(22'h000001, 32'h1234_5678, 1'b0, 1'b1, 4'hF)); end
        total++; if (rsp_cnt - rsp0 != 1) begin bad++; $display("FAIL read_rsp_count got=%0d exp=1", rsp_cnt - rsp0); end
        total++; if (rsp_rdata_seen !== 32'hDEADBEEF || rsp_err_seen !== 1'b0) begin bad++; $display("FAIL read_data got=%h err=%b exp=deadbeef/0", rsp_rdata_seen, rsp_err_seen); end
        total++; if (rsp_cyc - hs_cyc != exp_rel) begin bad++; $display("FAIL read_latency got=%0d exp=%0d", rsp_cyc - hs_cyc, exp_rel); end
        repeat (3) tick;
        total++; if (bus.host_rsp_rdata !== 32'hDEADBEEF || bus.host_rsp_valid !== 1'b0) begin bad++; $display("FAIL read_hold got=%h valid=%b", bus.host_rsp_rdata, bus.host_rsp_valid); end
    endtask

    task automatic test_posted_write;
        n_resp = 0;
        model_txn(1'b1, 1'b0);
        run_txn(22'h000010, 32'h5, 1'b1, 1'b0, 4'hF, 3);
        total++; if (!pd_stable || pd_first !== exp_pd(22'h10, 32'h5, 1'b1, 1'b0, 4'hF)) begin bad++; $display("FAIL posted_pd stable=%b got=%h", pd_stable, pd_first); end
        total++; if (pvld_after !== 1'b0) begin bad++; $display("FAIL posted_pvld_drop got=%b exp=0", pvld_after); end
        total++; if (rsp_cnt - rsp0 != 1 || rsp_cyc - hs_cyc != exp_rel) begin bad++; $display("FAIL posted_rsp count=%0d lat=%0d exp 1/%0d", rsp_cnt - rsp0, rsp_cyc - hs_cyc, exp_rel); end
        total++; if (rsp_rdata_seen !== 32'd0 || rsp_err_seen !== 1'b0 || rsp_to_seen !== 1'b0) begin bad++; $display("FAIL posted_data got=%h/%b/%b exp 0/0/0", rsp_rdata_seen, rsp_err_seen, rsp_to_seen); end
    endtask

    task automatic test_nonposted_error;
        n_resp = 1; resp_off[0] = 2; resp_pd[0] = {1'b1, 1'b1, 32'h0};
        model_txn(1'b1, 1'b1);
        run_txn(22'h2ABCD, 32'hCAFE_F00D, 1'b1, 1'b1, 4'h3, 1);
        total++; if (pd_first !== exp_pd(22'h2ABCD, 32'hCAFE_F00D, 1'b1, 1'b1, 4'h3)) begin bad++; $display("FAIL np_pd got=%h", pd_first); end
        total++; if (rsp_err_seen !== 1'b1 || rsp_to_seen !== 1'b0 || rsp_rdata_seen !== 32'd0) begin bad++; $display("FAIL np_err got=%b/%b/%h exp 1/0/0", rsp_err_seen, rsp_to_seen, rsp_rdata_seen); end
        total++; if (rsp_cyc - hs_cyc != exp_rel) begin bad++; $display("FAIL np_latency got=%0d exp=%0d", rsp_cyc - hs_cyc, exp_rel); end
    endtask

    task automatic test_timeout;
        n_resp = 1; resp_off[0] = T + 2; resp_pd[0] = {1'b0, 1'b0, 32'h7777_0001};
        model_txn(1'b0, 1'b0);
        run_txn(22'h00ABC, 32'h0, 1'b0, 1'b0, 4'hF, 0);
        total++; if (rsp_cnt - rsp0 != 1 || rsp_cyc - hs_cyc != T + 1) begin bad++; $display("FAIL timeout_latency count=%0d lat=%0d exp 1/%0d", rsp_cnt - rsp0, rsp_cyc - hs_cyc, T + 1); end
        total++; if (rsp_err_seen !== 1'b1 || rsp_to_seen !== 1'b1 || rsp_rdata_seen !== 32'd0) begin bad++; $display("FAIL timeout_flags got=%b/%b/%h exp 1/1/0", rsp_err_seen, rsp_to_seen, rsp_rdata_seen); end
        total++; if (unexp_cnt - unexp0 != exp_unexp) begin bad++; $display("FAIL timeout_late_resp got=%0d exp=%0d", unexp_cnt - unexp0, exp_unexp); end
    endtask

    task automatic test_mismatch;
        n_resp = 2;
        resp_off[0] = 1; resp_pd[0] = {1'b1, 1'b0, 32'h1111_1111};
        resp_off[1] = 3; resp_pd[1] = {1'b0, 1'b0, 32'h2222_3333};
        model_txn(1'b0, 1'b0);
        run_txn(22'h3FFFFF, 32'h0, 1'b0, 1'b0, 4'h1, 2);
        total++; if (unexp_cnt - unexp0 != 1) begin bad++; $display("FAIL mismatch_drop got=%0d exp=1", unexp_cnt - unexp0); end
        total++; if (rsp_rdata_seen !== 32'h2222_3333 || rsp_err_seen !== 1'b0 || rsp_to_seen !== 1'b0) begin bad++; $display("FAIL mismatch_data got=%h/%b/%b", rsp_rdata_seen, rsp_err_seen, rsp_to_seen); end
        total++; if (rsp_cyc - hs_cyc != exp_rel) begin bad++; $display("FAIL mismatch_latency got=%0d exp=%0d", rsp_cyc - hs_cyc, exp_rel); end
    endtask

    task automatic test_random;
        logic [21:0] a;
        logic [31:0] d;
        logic        w, np;
        logic [3:0]  be;
        int          pdly, o;
        for (int n = 0; n < 40; n++) begin
            a = 22'($urandom); d = $urandom; w = 1'($urandom); np = 1'($urandom);
            be = 4'($urandom); pdly = $urandom_range(0, 3);
            n_resp = (w && !np) ? 0 : $urandom_range(0, 2);
            o = $urandom_range(0, 2);
            for (int j = 0; j < n_resp; j++) begin
                resp_off[j] = o;
                o = o + $urandom_range(1, 5);
                resp_pd[j] = {1'($urandom), 1'($urandom), $urandom};
                if (j == n_resp - 1 && $urandom_range(0, 3) != 0) resp_pd[j][33] = w;
            end
            model_txn(w, np);
            run_txn(a, d, w, np, be, pdly);
            total++; if (acc_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready n=%0d got=%b", n, acc_ready); end
            total++; if (!pd_stable || pd_first !== exp_pd(a, d, w, np, be)) begin bad++; $display("FAIL rnd_pd n=%0d stable=%b got=%h exp=%h", n, pd_stable, pd_first, exp_pd(a, d, w, np, be)); end
            total++; if (rsp_cnt - rsp0 != 1 || rsp_cyc - hs_cyc != exp_rel) begin bad++; $display("FAIL rnd_rsp n=%0d count=%0d lat=%0d exp 1/%0d", n, rsp_cnt - rsp0, rsp_cyc - hs_cyc, exp_rel); end
            total++; if (rsp_rdata_seen !== exp_rdata || rsp_err_seen !== exp_err || rsp_to_seen !== exp_to) begin
                bad++; $display("FAIL rnd_data n=%0d got=%h/%b/%b exp=%h/%b/%b", n, rsp_rdata_seen, rsp_err_seen, rsp_to_seen, exp_rdata, exp_err, exp_to); end
            total++; if (unexp_cnt - unexp0 != exp_unexp) begin bad++; $display("FAIL rnd_unexp n=%0d got=%0d exp=%0d", n, unexp_cnt - unexp0, exp_unexp); end
            total++; if (rdy_at_rsp !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_turnaround n=%0d ready_at_rsp=%b busy=%b", n, rdy_at_rsp, bus.busy); end
        end
    endtask

    task automatic test_reset_mid;
        rsp0 = rsp_cnt;
        bus.cmd_addr = 22'h155; bus.cmd_write = 1'b0; bus.cmd_nposted = 1'b0;
        bus.cmd_wrbe = 4'hF; bus.cmd_valid = 1'b1; bus.csb_req_prdy = 1'b0;
        tick;
        bus.cmd_valid = 1'b0;
        total++; if (bus.csb_req_pvld !== 1'b1) begin bad++; $display("FAIL rstmid_pvld_before got=%b exp=1", bus.csb_req_pvld); end
        #2 rstn = 1'b0;
        #1;
        total++; if (bus.csb_req_pvld !== 1'b0) begin bad++; $display("FAIL rstmid_pvld_async got=%b exp=0", bus.csb_req_pvld); end
        repeat (2) tick;
        rstn = 1'b1;
        repeat (3) tick;
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle ready=%b busy=%b exp 1/0", bus.cmd_ready, bus.busy); end
        total++; if (rsp_cnt != rsp0) begin bad++; $display("FAIL rstmid_no_rsp got=%0d exp=0", rsp_cnt - rsp0); end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_posted_write;
        test_nonposted_error;
        test_timeout;
        test_mismatch;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end
endmodule
